// File: rtl/system_monitor_frame_tx.sv
// ---------------------------------------------------------------------------
// system_monitor_frame_tx
//
// Frame serializer that sits behind the system-monitor channel arbiter. A
// one-cycle `write` snapshots the selected channel payload and the address,
// then the frame is streamed one byte at a time into a UART transmitter:
//   SYNC_BYTE, {1'b0, address}, payload bytes (LSB first), [checksum]
// When the UART has finished the last byte, `write_done` pulses for one cycle.
//
// Build option: define SYSMON_FRAME_CHECKSUM_EN to append a checksum byte
// (two's complement of the mod-256 sum of address and payload bytes). With
// the macro undefined the frame ends after the last payload byte and no
// accumulator is built.
//
// Ports
//   clk, reset        single clock, synchronous active-high reset
//   write             one-cycle frame request from the arbiter
//   tx_address        7-bit address, latched on accept
//   tx_channel        payload select, used only at accept
//   channel_data      flattened payloads, channel c at [c*PAYLOAD_BYTES*8 +: PAYLOAD_BYTES*8]
//   uart_tx_busy      UART transmitter busy
//   uart_tx_data      byte to send, valid while uart_tx_start is high
//   uart_tx_start     one-cycle send strobe (registered)
//   write_done        one-cycle pulse once the frame is complete
//   frame_busy        high from the cycle after accept through write_done
//   write_overrun     sticky: write arrived while a frame was in progress
//   state_dbg         current FSM state, for observation only
//
// UART handshake: a byte is offered only when uart_tx_busy is low; the UART
// raises busy the cycle after uart_tx_start and drops it when the byte is
// gone, so each byte waits for busy to rise and then to fall.
// ---------------------------------------------------------------------------
module system_monitor_frame_tx #(
   parameter int          NUM_CH        = 8,
   parameter int          PAYLOAD_BYTES = 4,
   parameter logic [7:0]  SYNC_BYTE     = 8'hA5
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              write,
   input  logic [6:0]                        tx_address,
   input  logic [$clog2(NUM_CH)-1:0]         tx_channel,
   input  logic [NUM_CH*PAYLOAD_BYTES*8-1:0] channel_data,
   input  logic                              uart_tx_busy,
   output logic [7:0]                        uart_tx_data,
   output logic                              uart_tx_start,
   output logic                              write_done,
   output logic                              frame_busy,
   output logic                              write_overrun,
   output logic [2:0]                        state_dbg
);

   localparam int CH_W  = $clog2(NUM_CH);
   localparam int PW    = PAYLOAD_BYTES * 8;
   localparam int IDX_W = $clog2(PAYLOAD_BYTES + 3);
`ifdef SYSMON_FRAME_CHECKSUM_EN
   localparam int FRAME_LEN = PAYLOAD_BYTES + 3;
`else
   localparam int FRAME_LEN = PAYLOAD_BYTES + 2;
`endif
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SEND    = 3'd1,
      WAIT_HI = 3'd2,
      WAIT_LO = 3'd3,
      DONE    = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [6:0]       addr_q, addr_d;
   logic [PW-1:0]    payload_q, payload_d;
   logic             start_q, start_d;
   logic [7:0]       data_q, data_d;
   logic             overrun_q, overrun_d;
   logic [PW-1:0]    snap;
   logic [7:0]       cur_byte;
`ifdef SYSMON_FRAME_CHECKSUM_EN
   logic [7:0]       acc_q, acc_d;
`endif

   // Payload of the requested channel; out-of-range selects read as zero.
   always_comb begin
      snap = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (tx_channel == CH_W'(c)) snap = channel_data[c*PW +: PW];
      end
   end

   // Byte at the current frame position.
   always_comb begin
      cur_byte = '0;
      if (idx_q == '0) cur_byte = SYNC_BYTE;
      if (idx_q == IDX_W'(1)) cur_byte = {1'b0, addr_q};
      for (int i = 0; i < PAYLOAD_BYTES; i++) begin
         if (idx_q == IDX_W'(i + 2)) cur_byte = payload_q[i*8 +: 8];
      end
`ifdef SYSMON_FRAME_CHECKSUM_EN
      if (idx_q == LAST_IDX) cur_byte = 8'd0 - acc_q;
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         addr_q    <= '0;
         payload_q <= '0;
         start_q   <= 1'b0;
         data_q    <= '0;
         overrun_q <= 1'b0;
`ifdef SYSMON_FRAME_CHECKSUM_EN
         acc_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         addr_q    <= addr_d;
         payload_q <= payload_d;
         start_q   <= start_d;
         data_q    <= data_d;
         overrun_q <= overrun_d;
`ifdef SYSMON_FRAME_CHECKSUM_EN
         acc_q     <= acc_d;
`endif
      end
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      addr_d    = addr_q;
      payload_d = payload_q;
      start_d   = 1'b0;
      data_d    = '0;
      // Any write outside IDLE (DONE included) is dropped and remembered.
      overrun_d = overrun_q | (write && (state_q != IDLE));
`ifdef SYSMON_FRAME_CHECKSUM_EN
      acc_d     = acc_q;
`endif
      case (state_q)
         IDLE: begin
            if (write) begin
               addr_d    = tx_address;
               payload_d = snap;
               idx_d     = '0;
`ifdef SYSMON_FRAME_CHECKSUM_EN
               acc_d     = '0;
`endif
               state_d   = SEND;
            end
         end
         SEND: begin
            if (!uart_tx_busy) begin
               start_d = 1'b1;
               data_d  = cur_byte;
`ifdef SYSMON_FRAME_CHECKSUM_EN
               // The sync byte is framing, not content, so it stays out of the sum.
               if (idx_q != '0) acc_d = acc_q + cur_byte;
`endif
               state_d = WAIT_HI;
            end
         end
         WAIT_HI: begin
            if (uart_tx_busy) state_d = WAIT_LO;
         end
         WAIT_LO: begin
            if (!uart_tx_busy) begin
               if (idx_q == LAST_IDX) begin
                  state_d = DONE;
               end else begin
                  idx_d   = idx_q + IDX_W'(1);
                  state_d = SEND;
               end
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign uart_tx_start = start_q;
   assign uart_tx_data  = data_q;
   assign write_done    = (state_q == DONE);
   assign frame_busy    = (state_q != IDLE);
   assign write_overrun = overrun_q;
   assign state_dbg     = state_q;

endmodule
